// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-stage register.
package pipe_pkg;

  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned PC_W_DEF    = 32;
  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = '0;

  // One pipeline entry at default widths.
  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]    pc;
  } entry_t;

  // Occupancy encoding {main_v, skid_v}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// Single valid+data register with clear (priority) and load.
module pipe_skid_slot #(
  parameter int unsigned          DATA_W   = 64,
  parameter logic [DATA_W-1:0]    CLR_DATA = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Clear returns the slot to its bubble value; load captures a new entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= CLR_DATA;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= CLR_DATA;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_flop.sv
// Pipeline-stage register with valid/ready, optional skid entry, flush and stall counter.
module pipe_stage_flop
  import pipe_pkg::*;
#(
  parameter int unsigned        INSTR_W     = INSTR_W_DEF,
  parameter int unsigned        PC_W        = PC_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = '0,
  parameter bit                 SKID        = 1'b1,
  parameter int unsigned        STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   up_valid,
  output logic                   up_ready,
  input  logic [INSTR_W-1:0]     up_instr,
  input  logic [PC_W-1:0]        up_pc,
  output logic                   dn_valid,
  input  logic                   dn_ready,
  output logic [INSTR_W-1:0]     dn_instr,
  output logic [PC_W-1:0]        dn_pc,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned DATA_W = INSTR_W + PC_W;
  localparam logic [DATA_W-1:0] MAIN_CLR = {NOP_INSTR, PC_W'(0)};

  logic              w_main_v;
  logic              w_skid_v;
  logic [DATA_W-1:0] w_main_q;
  logic [DATA_W-1:0] w_skid_q;
  logic [DATA_W-1:0] w_main_din;
  logic              w_main_load;
  logic              w_main_clear;
  logic              w_main_from_skid;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_up_fire;
  logic              w_dn_fire;
  state_e            w_state;

  logic [STALL_CNT_W-1:0] r_stall_cnt;

  assign w_state   = state_e'({w_main_v, w_skid_v});
  assign w_up_fire = up_valid & up_ready;
  assign w_dn_fire = w_main_v & dn_ready;

  // Skid build: ready comes straight from a flop; plain build: ready looks through to dn_ready.
  generate
    if (SKID) begin : g_skid_ready
      assign up_ready = ~w_skid_v;
    end else begin : g_flop_ready
      assign up_ready = dn_ready | ~w_main_v;
    end
  endgenerate

  // Next-state decode: slot load/clear controls from occupancy and handshakes.
  always_comb begin
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (w_state)
        EMPTY: begin
          if (w_up_fire) w_main_load = 1'b1;
        end
        ONE: begin
          if (w_up_fire && w_dn_fire) begin
            w_main_load = 1'b1;
          end else if (w_up_fire) begin
            if (SKID) w_skid_load = 1'b1;
          end else if (w_dn_fire) begin
            w_main_clear = 1'b1;
          end
        end
        FULL: begin
          if (w_dn_fire) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
          end
        end
        default: begin
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign w_main_din = w_main_from_skid ? w_skid_q : {up_instr, up_pc};

  pipe_skid_slot #(
    .DATA_W   (DATA_W),
    .CLR_DATA (MAIN_CLR)
  ) u_main (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_din),
    .o_valid (w_main_v),
    .o_data  (w_main_q)
  );

  pipe_skid_slot #(
    .DATA_W   (DATA_W),
    .CLR_DATA (DATA_W'(0))
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  ({up_instr, up_pc}),
    .o_valid (w_skid_v),
    .o_data  (w_skid_q)
  );

  assign dn_valid = w_main_v;
  assign dn_instr = w_main_q[DATA_W-1:PC_W];
  assign dn_pc    = w_main_q[PC_W-1:0];

  // Saturating count of cycles where the consumer back-pressures a valid entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_main_v && !dn_ready && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

  // Producer must hold a refused entry unchanged until it is accepted.
  a_up_hold: assert property (@(posedge clock) disable iff (!reset)
    (up_valid && !up_ready && !flush) |=> (up_valid && $stable(up_instr) && $stable(up_pc)));

  // Skid slot is only ever occupied behind a valid main entry.
  a_state_legal: assert property (@(posedge clock) disable iff (!reset)
    !(w_skid_v && !w_main_v));

endmodule
